hazard_scoreboard_n: RTL and testbench

//  N-lane in-order issue hazard unit for the superscalar core; generalises the 2-lane A/B hazard/forwarding logic.

---
 rtl/hazard_scoreboard_n_pkg.sv | 12 +
 rtl/hazard_scoreboard_n_fwd_select_n.sv | 29 ++
 rtl/hazard_scoreboard_n.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard_n.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_n_pkg.sv
// hazard_scoreboard_n_pkg: shared types for the N-lane hazard/forwarding unit
package hazard_scoreboard_n_pkg;
  typedef enum logic [1:0] {NONE_f, INTRA_f, EX_MEM_f, MEM_WB_f} fwd_src_e;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb;
  } shadow_t;
  function automatic logic hits(shadow_t e, logic [4:0] s);
    return e.valid && e.wb && e.rd == s;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_n_fwd_select_n.sv
// fwd_select_n: priority forwarding source for one operand of one lane
module fwd_select_n
  import hazard_scoreboard_n_pkg::*;
#(
  parameter int W = 2,
  parameter int LANE = 0,
  localparam int FS = 2 + $clog2(W)
) (
  input  logic [4:0]      src,
  input  logic [W*5-1:0]  id_rd,
  input  logic [W-1:0]    id_wb,
  input  shadow_t [W-1:0] idex,
  input  shadow_t [W-1:0] exmem,
  output logic [FS-1:0]   sel
);
  fwd_src_e kind;
  int lane;
  // Lowest priority first so later matches (younger producers) overwrite
  always_comb begin
    kind = NONE_f;
    lane = 0;
    for (int i = 0; i < W; i++) if (hits(exmem[i], src)) begin kind = MEM_WB_f; lane = i; end
    for (int i = 0; i < W; i++) if (hits(idex[i], src)) begin kind = EX_MEM_f; lane = i; end
    for (int i = 0; i < W; i++)
      if (i < LANE && id_wb[i] && id_rd[i*5 +: 5] == src) begin kind = INTRA_f; lane = i; end
    if (src == '0) begin kind = NONE_f; lane = 0; end
    sel = (FS'(kind) << (FS - 2)) | FS'(lane);
  end
endmodule

// File: rtl/hazard_scoreboard_n.sv
// hazard_scoreboard_n: N-lane in-order issue hazard unit with load scoreboard and registered forwarding selects
module hazard_scoreboard_n
  import hazard_scoreboard_n_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  localparam int W  = ISSUE_W,
  localparam int FS = 2 + $clog2(ISSUE_W),
  localparam int CW = $clog2(LOAD_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    id_valid,
  input  logic [W*5-1:0]  id_rs1,
  input  logic [W*5-1:0]  id_rs2,
  input  logic [W-1:0]    id_use_rs1,
  input  logic [W-1:0]    id_use_rs2,
  input  logic [W*5-1:0]  id_rd,
  input  logic [W-1:0]    id_wb,
  input  logic [W-1:0]    id_load,
  input  logic            adv,
  input  logic            flush,
  output logic [W-1:0]    issue_mask,
  output logic [W-1:0]    ex_valid,
  output logic [W*FS-1:0] ex_fwd_a,
  output logic [W*FS-1:0] ex_fwd_b
);
  logic [CW-1:0]        cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  young;
  // No MEMWB shadow: its writes reach the write-through regfile and are never forwarded
  shadow_t [W-1:0]      idex, exmem;
  logic [W-1:0]         haz;
  logic [W-1:0][FS-1:0] sel_a, sel_b;
  logic                 go;
  always_comb begin
    haz = '0;
    for (int j = 0; j < W; j++) begin
      haz[j] = !id_valid[j]
        || (id_use_rs1[j] && id_rs1[j*5 +: 5] != '0 && cnt[id_rs1[j*5 +: 5]] != '0)
        || (id_use_rs2[j] && id_rs2[j*5 +: 5] != '0 && cnt[id_rs2[j*5 +: 5]] != '0);
      for (int i = 0; i < j; i++)
        haz[j] = haz[j] || (id_load[i] && id_rd[i*5 +: 5] != '0
          && ((id_use_rs1[j] && id_rd[i*5 +: 5] == id_rs1[j*5 +: 5])
           || (id_use_rs2[j] && id_rd[i*5 +: 5] == id_rs2[j*5 +: 5])));
    end
  end
  always_comb begin
    issue_mask = '0;
    go = adv && !flush;
    for (int j = 0; j < W; j++) begin
      go = go && !haz[j];
      issue_mask[j] = go;
    end
  end
  for (genvar j = 0; j < W; j++) begin : g_lane
    fwd_select_n #(.W(W), .LANE(j)) u_a (
      .src(id_rs1[j*5 +: 5]), .id_rd(id_rd), .id_wb(id_wb), .idex(idex), .exmem(exmem), .sel(sel_a[j])
    );
    fwd_select_n #(.W(W), .LANE(j)) u_b (
      .src(id_rs2[j*5 +: 5]), .id_rd(id_rd), .id_wb(id_wb), .idex(idex), .exmem(exmem), .sel(sel_b[j])
    );
  end
  // Issue writes come last so they override the decrement and the youngest lane wins WAW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      young <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (flush && young[r]) cnt[r] <= '0;
        else if (adv && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      if (flush || adv) young <= '0;
      for (int j = 0; j < W; j++)
        if (issue_mask[j] && (id_wb[j] || id_load[j]) && id_rd[j*5 +: 5] != '0) begin
          cnt[id_rd[j*5 +: 5]]   <= id_load[j] ? CW'(LOAD_LAT) : '0;
          young[id_rd[j*5 +: 5]] <= id_load[j];
        end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex     <= '0;
      exmem    <= '0;
      ex_valid <= '0;
      ex_fwd_a <= '0;
      ex_fwd_b <= '0;
    end else begin
      if (adv) exmem <= idex;
      if (flush) begin
        idex     <= '0;
        ex_valid <= '0;
        ex_fwd_a <= '0;
        ex_fwd_b <= '0;
      end else if (adv) begin
        ex_valid <= issue_mask;
        for (int j = 0; j < W; j++) begin
          idex[j]              <= '{valid: issue_mask[j], rd: id_rd[j*5 +: 5], wb: id_wb[j]};
          ex_fwd_a[j*FS +: FS] <= issue_mask[j] ? sel_a[j] : '0;
          ex_fwd_b[j*FS +: FS] <= issue_mask[j] ? sel_b[j] : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_n.sv
// tb_hazard_scoreboard_n: scoreboard bench for the 2-lane hazard unit (LOAD_LAT 1 and 3)
module tb_hazard_scoreboard_n;
  typedef struct packed {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, wb, ld;
  } lane_t;
  typedef struct packed {
    logic [1:0] v;
    logic [5:0] a, b, m;
  } ex_t;
  typedef struct packed {
    logic       adv, flush;
    lane_t      l0, l1;
    logic [1:0] mask;
    ex_t        ex;
  } step_t;
  localparam lane_t NL = '0;
  logic clk = 0, rst_n = 0;
  logic [1:0] id_valid, id_use_rs1, id_use_rs2, id_wb, id_load;
  logic [9:0] id_rs1, id_rs2, id_rd;
  logic adv, flush;
  logic [1:0] issue_mask, ex_valid, issue_mask3, ex_valid3;
  logic [5:0] ex_fwd_a, ex_fwd_b, ex_fwd_a3, ex_fwd_b3;
  int vecs = 0, errs = 0;
  logic [1:0] q_mask[$];
  ex_t q_ex[$];
  logic [1:0] em;
  ex_t ee;
  always #5 clk = ~clk;
  hazard_scoreboard_n #(.ISSUE_W(2), .NUM_REGS(32), .LOAD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wb(id_wb),
    .id_load(id_load), .adv(adv), .flush(flush), .issue_mask(issue_mask),
    .ex_valid(ex_valid), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );
  hazard_scoreboard_n #(.ISSUE_W(2), .NUM_REGS(32), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wb(id_wb),
    .id_load(id_load), .adv(adv), .flush(flush), .issue_mask(issue_mask3),
    .ex_valid(ex_valid3), .ex_fwd_a(ex_fwd_a3), .ex_fwd_b(ex_fwd_b3)
  );
  function automatic lane_t L(int rd, int rs1, int rs2, int u1, int u2, int wb, int ld);
    return {1'b1, 5'(rd), 5'(rs1), 5'(rs2), 1'(u1), 1'(u2), 1'(wb), 1'(ld)};
  endfunction
  function automatic step_t S(int a, int f, lane_t l0, lane_t l1, logic [1:0] mk, logic [1:0] v,
                              logic [5:0] fa, logic [5:0] fb, logic [5:0] m);
    return {1'(a), 1'(f), l0, l1, mk, v, fa, fb, m};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input step_t s);
    adv = s.adv;
    flush = s.flush;
    id_valid = {s.l1.v, s.l0.v};
    id_rd = {s.l1.rd, s.l0.rd};
    id_rs1 = {s.l1.rs1, s.l0.rs1};
    id_rs2 = {s.l1.rs2, s.l0.rs2};
    id_use_rs1 = {s.l1.u1, s.l0.u1};
    id_use_rs2 = {s.l1.u2, s.l0.u2};
    id_wb = {s.l1.wb, s.l0.wb};
    id_load = {s.l1.ld, s.l0.ld};
    q_mask.push_back(s.mask);
    q_ex.push_back(s.ex);
  endtask
  task automatic test_reset();
    apply(S(0, 0, NL, NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o77));
    #12 rst_n = 1;
    void'(q_mask.pop_front());
    ee = q_ex.pop_front(); vecs++;
    if (ex_valid !== ee.v || ex_fwd_a !== ee.a || ex_fwd_b !== ee.b) begin
      errs++; $display("FAIL reset ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", ex_valid, ex_fwd_a, ex_fwd_b, ee.v, ee.a, ee.b);
    end
    tick();
    apply(S(1, 0, NL, NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o77));
    #1 em = q_mask.pop_front(); vecs++;
    if (issue_mask !== em) begin errs++; $display("FAIL reset issue_mask: got %b want %b", issue_mask, em); end
    tick(); ee = q_ex.pop_front(); vecs++;
    if (ex_valid !== ee.v || ex_fwd_a !== ee.a || ex_fwd_b !== ee.b) begin
      errs++; $display("FAIL reset idle ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", ex_valid, ex_fwd_a, ex_fwd_b, ee.v, ee.a, ee.b);
    end
  endtask
  task automatic test_load_use();
    step_t t[3];
    t[0] = S(1, 0, L(5, 2, 0, 1, 0, 1, 1), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o07);
    t[1] = S(1, 0, L(6, 5, 1, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o00);
    t[2] = S(1, 0, L(6, 5, 1, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o06, 6'o00, 6'o07);
    foreach (t[c]) begin
      apply(t[c]);
      #1 em = q_mask.pop_front(); vecs++;
      if (issue_mask !== em) begin errs++; $display("FAIL load_use[%0d] issue_mask: got %b want %b", c, issue_mask, em); end
      tick(); ee = q_ex.pop_front(); vecs++;
      if (ex_valid !== ee.v || (ex_fwd_a & ee.m) !== (ee.a & ee.m) || (ex_fwd_b & ee.m) !== (ee.b & ee.m)) begin
        errs++; $display("FAIL load_use[%0d] ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", c, ex_valid, ex_fwd_a & ee.m, ex_fwd_b & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
      end
    end
  endtask
  task automatic test_intra_split();
    step_t t[4];
    t[0] = S(1, 0, L(3, 2, 0, 1, 0, 1, 0), L(4, 3, 3, 1, 1, 1, 0), 2'b11, 2'b11, 6'o20, 6'o20, 6'o77);
    t[1] = S(1, 0, L(3, 2, 0, 1, 0, 1, 1), L(4, 3, 0, 1, 1, 1, 0), 2'b01, 2'b01, 6'o00, 6'o00, 6'o07);
    t[2] = S(1, 0, L(4, 3, 0, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o00);
    t[3] = S(1, 0, L(4, 3, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o06, 6'o00, 6'o07);
    foreach (t[c]) begin
      apply(t[c]);
      #1 em = q_mask.pop_front(); vecs++;
      if (issue_mask !== em) begin errs++; $display("FAIL intra_split[%0d] issue_mask: got %b want %b", c, issue_mask, em); end
      tick(); ee = q_ex.pop_front(); vecs++;
      if (ex_valid !== ee.v || (ex_fwd_a & ee.m) !== (ee.a & ee.m) || (ex_fwd_b & ee.m) !== (ee.b & ee.m)) begin
        errs++; $display("FAIL intra_split[%0d] ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", c, ex_valid, ex_fwd_a & ee.m, ex_fwd_b & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
      end
    end
  endtask
  task automatic test_youngest();
    step_t t[4];
    t[0] = S(1, 0, L(7, 1, 0, 1, 0, 1, 0), L(7, 1, 0, 1, 0, 1, 0), 2'b11, 2'b11, 6'o00, 6'o00, 6'o77);
    t[1] = S(1, 0, L(8, 7, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o05, 6'o00, 6'o07);
    t[2] = S(1, 0, L(10, 7, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o07, 6'o00, 6'o07);
    t[3] = S(1, 0, L(0, 10, 0, 1, 0, 1, 0), L(9, 0, 0, 1, 1, 1, 0), 2'b11, 2'b11, 6'o04, 6'o00, 6'o77);
    foreach (t[c]) begin
      apply(t[c]);
      #1 em = q_mask.pop_front(); vecs++;
      if (issue_mask !== em) begin errs++; $display("FAIL youngest[%0d] issue_mask: got %b want %b", c, issue_mask, em); end
      tick(); ee = q_ex.pop_front(); vecs++;
      if (ex_valid !== ee.v || (ex_fwd_a & ee.m) !== (ee.a & ee.m) || (ex_fwd_b & ee.m) !== (ee.b & ee.m)) begin
        errs++; $display("FAIL youngest[%0d] ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", c, ex_valid, ex_fwd_a & ee.m, ex_fwd_b & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
      end
    end
  endtask
  task automatic test_hold_flush();
    step_t t[9];
    t[0] = S(1, 0, L(11, 9, 0, 1, 0, 1, 1), NL, 2'b01, 2'b01, 6'o05, 6'o00, 6'o07);
    t[1] = S(0, 0, L(12, 11, 0, 1, 1, 1, 0), NL, 2'b00, 2'b01, 6'o05, 6'o00, 6'o07);
    t[2] = t[1];
    t[3] = t[1];
    t[4] = S(1, 0, L(12, 11, 0, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o00);
    t[5] = S(1, 0, L(12, 11, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o06, 6'o00, 6'o07);
    t[6] = S(1, 0, L(13, 12, 0, 1, 0, 1, 1), NL, 2'b01, 2'b01, 6'o04, 6'o00, 6'o07);
    t[7] = S(0, 1, L(14, 13, 0, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o77);
    t[8] = S(1, 0, L(14, 13, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o07);
    foreach (t[c]) begin
      apply(t[c]);
      #1 em = q_mask.pop_front(); vecs++;
      if (issue_mask !== em) begin errs++; $display("FAIL hold_flush[%0d] issue_mask: got %b want %b", c, issue_mask, em); end
      tick(); ee = q_ex.pop_front(); vecs++;
      if (ex_valid !== ee.v || (ex_fwd_a & ee.m) !== (ee.a & ee.m) || (ex_fwd_b & ee.m) !== (ee.b & ee.m)) begin
        errs++; $display("FAIL hold_flush[%0d] ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", c, ex_valid, ex_fwd_a & ee.m, ex_fwd_b & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
      end
    end
  endtask
  task automatic test_reset_mid();
    apply(S(1, 0, L(9, 1, 0, 1, 0, 1, 1), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o00));
    #1 em = q_mask.pop_front(); vecs++;
    if (issue_mask !== em) begin errs++; $display("FAIL reset_mid load issue_mask: got %b want %b", issue_mask, em); end
    tick(); ee = q_ex.pop_front(); vecs++;
    if (ex_valid !== ee.v) begin errs++; $display("FAIL reset_mid load ex_valid: got %b want %b", ex_valid, ee.v); end
    apply(S(0, 0, NL, NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o77));
    void'(q_mask.pop_front());
    #2 rst_n = 0;
    #1 ee = q_ex.pop_front(); vecs++;
    if (ex_valid !== ee.v || ex_fwd_a !== ee.a || ex_fwd_b !== ee.b) begin
      errs++; $display("FAIL reset_mid async: got v=%b a=%o b=%o want v=%b a=%o b=%o", ex_valid, ex_fwd_a, ex_fwd_b, ee.v, ee.a, ee.b);
    end
    rst_n = 1;
    apply(S(1, 0, L(10, 9, 1, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o07));
    #1 em = q_mask.pop_front(); vecs++;
    if (issue_mask !== em) begin errs++; $display("FAIL reset_mid cnt cleared issue_mask: got %b want %b", issue_mask, em); end
    tick(); ee = q_ex.pop_front(); vecs++;
    if (ex_valid !== ee.v || (ex_fwd_a & ee.m) !== (ee.a & ee.m) || (ex_fwd_b & ee.m) !== (ee.b & ee.m)) begin
      errs++; $display("FAIL reset_mid after ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", ex_valid, ex_fwd_a & ee.m, ex_fwd_b & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
    end
  endtask
  task automatic test_lat3();
    step_t t[6];
    t[0] = S(1, 0, L(20, 1, 0, 1, 0, 1, 1), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o00);
    t[1] = S(1, 0, L(21, 20, 0, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o00);
    t[2] = S(0, 0, L(21, 20, 0, 1, 1, 1, 0), NL, 2'b00, 2'b00, 6'o00, 6'o00, 6'o00);
    t[3] = t[1];
    t[4] = t[1];
    t[5] = S(1, 0, L(21, 20, 0, 1, 1, 1, 0), NL, 2'b01, 2'b01, 6'o00, 6'o00, 6'o07);
    foreach (t[c]) begin
      apply(t[c]);
      #1 em = q_mask.pop_front(); vecs++;
      if (issue_mask3 !== em) begin errs++; $display("FAIL lat3[%0d] issue_mask: got %b want %b", c, issue_mask3, em); end
      tick(); ee = q_ex.pop_front(); vecs++;
      if (ex_valid3 !== ee.v || (ex_fwd_a3 & ee.m) !== (ee.a & ee.m) || (ex_fwd_b3 & ee.m) !== (ee.b & ee.m)) begin
        errs++; $display("FAIL lat3[%0d] ex: got v=%b a=%o b=%o want v=%b a=%o b=%o", c, ex_valid3, ex_fwd_a3 & ee.m, ex_fwd_b3 & ee.m, ee.v, ee.a & ee.m, ee.b & ee.m);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_load_use();
    test_intra_split();
    test_youngest();
    test_hold_flush();
    test_reset_mid();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
